// File: rtl/uart_mmio_pkg.sv
// Shared constants for the memory-mapped UART: register offsets, STATUS bit
// positions and the TX/RX state encodings.
package uart_mmio_pkg;

    localparam logic [7:0] UART_STATUS = 8'h00;
    localparam logic [7:0] UART_RX     = 8'h04;
    localparam logic [7:0] UART_TX     = 8'h08;
    localparam logic [7:0] CYC_CNT     = 8'h10;
    localparam logic [7:0] CYC_RST     = 8'h18;

    localparam int unsigned STATUS_TX_READY  = 0;
    localparam int unsigned STATUS_RX_VALID  = 1;
    localparam int unsigned STATUS_FRAME_ERR = 2;
    localparam int unsigned STATUS_OVERRUN   = 3;

    typedef enum logic {
        TxIdle,
        TxSend
    } tx_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

endpackage

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronizer, mid-bit start qualification, 8 data
// samples LSB first and a stop-bit check producing done/frame-error pulses.
module uart_receiver
    import uart_mmio_pkg::*;
#(
    parameter int unsigned SYMBOL_EDGE_TIME = 434,
    parameter int unsigned SAMPLE_TIME      = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       done_o,
    output logic       ferr_o,
    output logic [7:0] byte_o
);

    localparam int unsigned CntW = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam logic [CntW-1:0] BitEnd    = CntW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CntW-1:0] SampleEnd = CntW'(SAMPLE_TIME - 1);

    logic            sync1_q, sync2_q;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_o  = 1'b0;
        ferr_o  = 1'b0;
        unique case (state_q)
            RxIdle: begin
                if (!sync2_q) begin
                    state_d = RxStart;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            RxStart: begin
                if (baud_q == SampleEnd) begin
                    baud_d  = '0;
                    // A line already back high at mid-start-bit is treated as a glitch.
                    state_d = sync2_q ? RxIdle : RxData;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            RxData: begin
                if (baud_q == BitEnd) begin
                    baud_d  = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        state_d = RxStop;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            RxStop: begin
                if (baud_q == BitEnd) begin
                    baud_d  = '0;
                    state_d = RxIdle;
                    done_o  = sync2_q;
                    ferr_o  = !sync2_q;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RxIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 10-bit frame shift register sent LSB first, each bit held
// SYMBOL_EDGE_TIME cycles; loads are ignored while a frame is in flight.
module uart_transmitter
    import uart_mmio_pkg::*;
#(
    parameter int unsigned SYMBOL_EDGE_TIME = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       ready_o
);

    localparam int unsigned CntW = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam logic [CntW-1:0] BitEnd = CntW'(SYMBOL_EDGE_TIME - 1);

    tx_state_e       state_q, state_d;
    logic [9:0]      shift_q, shift_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [3:0]      bit_q, bit_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        unique case (state_q)
            TxIdle: begin
                if (load_i) begin
                    shift_d = {1'b1, data_i, 1'b0};
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TxSend;
                end
            end
            TxSend: begin
                if (baud_q == BitEnd) begin
                    baud_d  = '0;
                    shift_d = {1'b1, shift_q[9:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd9) begin
                        state_d = TxIdle;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TxIdle;
            shift_q <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
        end
    end

    // Shift register refills with ones, so the line is already high when SEND ends.
    assign tx_o    = (state_q == TxSend) ? shift_q[0] : 1'b1;
    assign ready_o = (state_q == TxIdle);

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: address decode, status flags, cycle counter and the
// registered read port; serial framing lives in the TX/RX sub-modules.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int unsigned CPU_CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE      = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        serial_rx,
    output logic        serial_tx
);

    localparam int unsigned SYMBOL_EDGE_TIME = CPU_CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;

    logic [7:0]  off;
    logic        wr_en, rd_en;
    logic        tx_load, cnt_clr, stat_wr, rx_rd;
    logic        tx_ready, rx_done, rx_ferr;
    logic [7:0]  rx_byte_new;
    logic [31:0] status;

    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic unused_bits;
    assign unused_bits = ^{addr[30:8], wdata[31:8]};

    assign off     = addr[7:0];
    assign wr_en   = addr[31] && (we != 4'h0);
    assign rd_en   = addr[31] && re;
    assign tx_load = wr_en && (off == UART_TX);
    assign cnt_clr = wr_en && (off == CYC_RST);
    assign stat_wr = wr_en && (off == UART_STATUS);
    assign rx_rd   = rd_en && (off == UART_RX);

    uart_transmitter #(
        .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .load_i (tx_load),
        .data_i (wdata[7:0]),
        .tx_o   (serial_tx),
        .ready_o(tx_ready)
    );

    uart_receiver #(
        .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME),
        .SAMPLE_TIME     (SAMPLE_TIME)
    ) u_rx (
        .clk   (clk),
        .rst   (rst),
        .rx_i  (serial_rx),
        .done_o(rx_done),
        .ferr_o(rx_ferr),
        .byte_o(rx_byte_new)
    );

    always_comb begin
        status = '0;
        status[STATUS_TX_READY]  = tx_ready;
        status[STATUS_RX_VALID]  = rx_valid_q;
        status[STATUS_FRAME_ERR] = frame_err_q;
        status[STATUS_OVERRUN]   = overrun_q;
    end

    // Hardware set has priority over software clear for every flag.
    always_comb begin
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        rx_byte_d   = rx_byte_q;
        if (rx_done) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = rx_byte_new;
        end else if (rx_rd) begin
            rx_valid_d = 1'b0;
        end
        if (rx_done && rx_valid_q && !rx_rd) begin
            overrun_d = 1'b1;
        end else if (stat_wr && wdata[STATUS_OVERRUN]) begin
            overrun_d = 1'b0;
        end
        if (rx_ferr) begin
            frame_err_d = 1'b1;
        end else if (stat_wr && wdata[STATUS_FRAME_ERR]) begin
            frame_err_d = 1'b0;
        end
    end

    always_comb begin
        cycle_cnt_d = cnt_clr ? 32'd0 : cycle_cnt_q + 32'd1;
        rdata_d     = rdata_q;
        if (rd_en) begin
            case (off)
                UART_STATUS: rdata_d = status;
                UART_RX:     rdata_d = {24'b0, rx_byte_q};
                CYC_CNT:     rdata_d = cycle_cnt_q;
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_byte_q   <= '0;
            cycle_cnt_q <= '0;
            rdata_q     <= '0;
        end else begin
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_byte_q   <= rx_byte_d;
            cycle_cnt_q <= cycle_cnt_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio at 10 cycles per bit: register-map vector
// table followed by TX, RX, counter and reset corner-case sequences.
module tb_uart_mmio;

    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RX     = 32'h8000_0004;
    localparam logic [31:0] A_TX     = 32'h8000_0008;
    localparam logic [31:0] A_CNT    = 32'h8000_0010;
    localparam logic [31:0] A_CNTRST = 32'h8000_0018;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic [31:0] rdata;
    logic        serial_rx;
    logic        serial_tx;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        re;
        logic [31:0] exp;
        logic        chk;
    } vec_t;

    vec_t vecs[15];

    uart_mmio #(
        .CPU_CLOCK_FREQ(1_000_000),
        .BAUD_RATE     (100_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .rdata    (rdata),
        .serial_rx(serial_rx),
        .serial_tx(serial_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic idle_bus();
        addr  = '0;
        wdata = '0;
        we    = '0;
        re    = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 4'hF;
        re    = 1'b0;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr = a;
        re   = 1'b1;
        we   = '0;
        @(posedge clk);
        #1;
        check(name, rdata, exp);
        idle_bus();
    endtask

    // Drives one frame on serial_rx, changing bits on negedges, then idles high.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            serial_rx = fr[i];
            repeat (10) @(negedge clk);
        end
        serial_rx = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Cycle k is the state after the k-th edge following the TX_DATA write edge.
    task automatic tx_frame(input logic [7:0] b, input logic poll);
        logic [9:0] fr;
        logic       exp_bit;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k <= 101; k++) begin
            @(negedge clk);
            idle_bus();
            if (k == 0) begin
                addr = A_TX; we = 4'hF; wdata = {24'h0, b};
            end else if (poll && k == 50) begin
                addr = A_TX; we = 4'hF; wdata = 32'h3C;
            end else if (poll && (k == 30 || k == 100 || k == 101)) begin
                addr = A_STATUS; re = 1'b1;
            end
            @(posedge clk);
            #1;
            exp_bit = (k < 100) ? fr[k/10] : 1'b1;
            check($sformatf("tx_bit_k%0d", k), {31'b0, serial_tx}, {31'b0, exp_bit});
            if (poll && (k == 30 || k == 100)) check("tx_busy_status", rdata, 32'h0);
            if (poll && k == 101) check("tx_done_status", rdata, 32'h1);
        end
        idle_bus();
    endtask

    initial begin
        int lows;
        idle_bus();
        serial_rx = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_line", {31'b0, serial_tx}, 32'h1);
        check("reset_rdata", rdata, 32'h0);
        rst = 1'b1;

        vecs[0]  = '{A_STATUS,      4'h0, 32'h0,        1'b1, 32'h1,  1'b1};
        vecs[1]  = '{A_RX,          4'h0, 32'h0,        1'b1, 32'h0,  1'b1};
        vecs[2]  = '{A_STATUS,      4'hF, 32'hF,        1'b0, 32'h0,  1'b0};
        vecs[3]  = '{A_STATUS,      4'h0, 32'h0,        1'b1, 32'h1,  1'b1};
        vecs[4]  = '{32'h8000_000C, 4'h0, 32'h0,        1'b1, 32'h0,  1'b1};
        vecs[5]  = '{A_STATUS,      4'h0, 32'h0,        1'b1, 32'h1,  1'b1};
        vecs[6]  = '{32'h8000_000C, 4'h0, 32'h0,        1'b0, 32'h1,  1'b1};
        vecs[7]  = '{32'h0000_0000, 4'h0, 32'h0,        1'b1, 32'h1,  1'b1};
        vecs[8]  = '{32'h8000_000C, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0};
        vecs[9]  = '{A_STATUS,      4'h0, 32'h0,        1'b1, 32'h1,  1'b1};
        vecs[10] = '{32'h0000_0008, 4'hF, 32'hA5,       1'b0, 32'h0,  1'b0};
        vecs[11] = '{A_STATUS,      4'h0, 32'h0,        1'b1, 32'h1,  1'b1};
        vecs[12] = '{A_TX,          4'h0, 32'h0,        1'b1, 32'h0,  1'b1};
        vecs[13] = '{A_STATUS,      4'h0, 32'h0,        1'b1, 32'h1,  1'b1};
        vecs[14] = '{32'h8000_0014, 4'h0, 32'h0,        1'b1, 32'h0,  1'b1};

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            addr  = vecs[i].addr;
            we    = vecs[i].we;
            wdata = vecs[i].wdata;
            re    = vecs[i].re;
            @(posedge clk);
            #1;
            if (vecs[i].chk) check($sformatf("vec%0d", i), rdata, vecs[i].exp);
        end
        idle_bus();
        check("tx_idle_after_table", {31'b0, serial_tx}, 32'h1);

        // TX frame with status polling and a dropped mid-frame write.
        tx_frame(8'hA5, 1'b1);
        lows = 0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (!serial_tx) lows++;
        end
        check("tx_dropped_write_low_cycles", lows, 0);

        // RX good byte.
        send_rx(8'h5A, 1'b1);
        read_check("rx_status_valid", A_STATUS, 32'h3);
        read_check("rx_data", A_RX, 32'h5A);
        read_check("rx_status_cleared", A_STATUS, 32'h1);

        // Short glitch must not start a frame.
        @(negedge clk);
        serial_rx = 1'b0;
        repeat (3) @(negedge clk);
        serial_rx = 1'b1;
        repeat (30) @(negedge clk);
        read_check("glitch_status", A_STATUS, 32'h1);
        read_check("glitch_rx_data", A_RX, 32'h5A);

        // Stop bit 0: frame error, byte discarded.
        send_rx(8'h77, 1'b0);
        read_check("ferr_status", A_STATUS, 32'h5);
        read_check("ferr_rx_data", A_RX, 32'h5A);

        // Two bytes without a read: overrun, newest byte kept.
        send_rx(8'h11, 1'b1);
        read_check("first_byte_status", A_STATUS, 32'h7);
        send_rx(8'h22, 1'b1);
        read_check("overrun_status", A_STATUS, 32'hF);
        read_check("overrun_rx_data", A_RX, 32'h22);
        read_check("after_read_status", A_STATUS, 32'hD);
        bus_write(A_STATUS, 32'hC);
        read_check("w1c_status", A_STATUS, 32'h1);

        // Counter clear: reads capture the count before the read edge.
        bus_write(A_CNTRST, 32'h0);
        read_check("cnt_after_clear", A_CNT, 32'd0);
        read_check("cnt_second", A_CNT, 32'd1);
        repeat (2) @(posedge clk);
        read_check("cnt_read_at_w5", A_CNT, 32'd4);

        // Wrap from all-ones.
        @(negedge clk);
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        addr = A_CNT;
        re   = 1'b1;
        #2;
        release dut.cycle_cnt_q;
        @(posedge clk);
        #1;
        check("cnt_max", rdata, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("cnt_wrap", rdata, 32'h0);
        idle_bus();

        // Reset in the middle of a frame (bit 4, data all zeros).
        bus_write(A_TX, 32'h00);
        repeat (44) @(posedge clk);
        #1;
        check("pre_reset_tx_bit4", {31'b0, serial_tx}, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check("midframe_reset_tx", {31'b0, serial_tx}, 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        read_check("post_reset_status", A_STATUS, 32'h1);
        tx_frame(8'h96, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
